ps2_device_rxtx: RTL and testbench

- Device-side (keyboard/mouse end) PS/2 transceiver. It owns the PS/2 clock: it sends device-to-host frames and accepts host-to-device command frames.
- It emulates a PS/2 peripheral on the bench against the host transceiver. It is also the core for FPGA-to-FPGA PS/2 links.
- Pins are open-drain. The top level ties each *_oe to a pulldown: line = oe ? 0 : z, with pull-up.

---
 rtl/ps2_dev_pkg.sv | 28 ++
 rtl/ps2_dev_cellgen.sv | 65 ++++++
 rtl/ps2_device_rxtx.sv | 168 ++++++++++++++++
 tb/tb_ps2_device_rxtx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_dev_pkg.sv
// Shared types and frame constants for the device-side PS/2 transceiver.
package ps2_dev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_HOST_HOLD,
    ST_RX,
    ST_ACK,
    ST_GAP
  } state_t;

  // TX cells start with the clock high, RX cells start with it low
  typedef enum logic {
    MODE_TX,
    MODE_RX
  } cell_mode_t;

  localparam int   FRAME_BITS     = 11;
  localparam int   RX_SAMPLE_BITS = 10;
  localparam logic START          = 1'b0;
  localparam logic STOP           = 1'b1;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_dev_cellgen.sv
// Cell timer for generated PS/2 clock: two half-periods per cell, 11 cells per frame.
module ps2_dev_cellgen
  import ps2_dev_pkg::*;
#(
  parameter int HALF_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  cell_mode_t mode,
  output logic       phase_high,
  output logic       cell_start,
  output logic       phase_end,
  output logic       mid_high,
  output logic       cell_end,
  output logic [3:0] cell_idx
);

  localparam int             TW        = $clog2(HALF_CYCLES);
  localparam logic [TW-1:0]  T_LAST    = TW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0]  T_MID     = TW'(HALF_CYCLES / 2);
  localparam logic [3:0]     LAST_CELL = 4'(FRAME_BITS - 1);

  logic          busy;
  logic          second_half;
  logic [TW-1:0] timer;

  // The frame stops by itself after the last cell; clear kills it early
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      second_half <= 1'b0;
      phase_high  <= 1'b0;
      timer       <= '0;
      cell_idx    <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (start) begin
      busy        <= 1'b1;
      second_half <= 1'b0;
      phase_high  <= (mode == MODE_TX);
      timer       <= '0;
      cell_idx    <= '0;
    end else if (busy) begin
      if (timer == T_LAST) begin
        timer       <= '0;
        phase_high  <= ~phase_high;
        second_half <= ~second_half;
        if (second_half) begin
          if (cell_idx == LAST_CELL) busy <= 1'b0;
          else cell_idx <= cell_idx + 4'd1;
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign phase_end  = busy && (timer == T_LAST);
  assign cell_end   = phase_end && second_half;
  assign cell_start = busy && !second_half && (timer == '0);
  assign mid_high   = busy && phase_high && (timer == T_MID);

endmodule

// File: rtl/ps2_device_rxtx.sv
// Device-side PS/2 transceiver: owns the PS/2 clock, sends device frames, accepts host commands.
module ps2_device_rxtx
  import ps2_dev_pkg::*;
#(
  parameter int HALF_CYCLES = 2000,
  parameter int GAP_CYCLES  = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_stb,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_parity_err
);

  localparam int            IW        = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] GAP_LAST  = IW'(GAP_CYCLES);
  localparam logic [3:0]    LAST_CELL = 4'(FRAME_BITS - 1);
  localparam logic [3:0]    STOP_CELL = 4'(RX_SAMPLE_BITS - 1);

  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic       clk_s, data_s;
  logic [IW-1:0] idle_cnt;
  logic       bus_idle;
  logic [2:0] clk_hist;
  logic       pending_valid;
  logic [7:0] pending_byte;
  logic [RX_SAMPLE_BITS-1:0] rx_bits;
  logic [FRAME_BITS-1:0]     tx_frame;
  logic       cg_start, cg_clear, cg_phase_high, cg_cell_start;
  logic       cg_phase_end, cg_mid_high, cg_cell_end;
  logic [3:0] cg_cell_idx;
  cell_mode_t cg_mode;
  logic       done_n, abort_n, valid_n;

  ps2_dev_cellgen #(.HALF_CYCLES(HALF_CYCLES)) u_cellgen (
    .clk        (clk),
    .rst        (rst),
    .start      (cg_start),
    .clear      (cg_clear),
    .mode       (cg_mode),
    .phase_high (cg_phase_high),
    .cell_start (cg_cell_start),
    .phase_end  (cg_phase_end),
    .mid_high   (cg_mid_high),
    .cell_end   (cg_cell_end),
    .cell_idx   (cg_cell_idx)
  );

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign bus_idle = (idle_cnt == GAP_LAST);
  assign tx_ready = (state == ST_IDLE) && !pending_valid && bus_idle;
  assign tx_frame = {STOP, odd_parity(pending_byte), pending_byte, START};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      clk_sync      <= 2'b11;
      data_sync     <= 2'b11;
      idle_cnt      <= '0;
      clk_hist      <= '0;
      pending_valid <= 1'b0;
      pending_byte  <= '0;
      rx_bits       <= '0;
      tx_done       <= 1'b0;
      tx_abort      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
    end else begin
      state     <= state_n;
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_hist  <= {clk_hist[1:0], ps2_clk_oe};
      if (!(clk_s && data_s)) idle_cnt <= '0;
      else if (!bus_idle) idle_cnt <= idle_cnt + 1'b1;
      tx_done  <= done_n;
      tx_abort <= abort_n;
      rx_valid <= valid_n;
      if (done_n) pending_valid <= 1'b0;
      else if (tx_stb && tx_ready) begin
        pending_valid <= 1'b1;
        pending_byte  <= tx_data;
      end
      if (state == ST_RX && cg_cell_start && cg_cell_idx == 4'd0) rx_bits <= '0;
      else if (state == ST_RX && cg_mid_high) rx_bits[cg_cell_idx] <= data_s;
      if (valid_n) begin
        rx_data       <= rx_bits[7:0];
        rx_parity_err <= ~^rx_bits[8:0];
      end
    end
  end

  // clk_hist masks our own just-released clock edge still working through the synchronizer
  always_comb begin
    state_n  = state;
    cg_start = 1'b0;
    cg_clear = 1'b0;
    cg_mode  = MODE_TX;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    valid_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!clk_s) state_n = ST_HOST_HOLD;
        else if (pending_valid && bus_idle) begin
          state_n  = ST_TX;
          cg_start = 1'b1;
        end
      end
      ST_TX: begin
        if (cg_phase_end && cg_phase_high && cg_cell_idx < LAST_CELL && !clk_s) begin
          state_n  = ST_IDLE;
          cg_clear = 1'b1;
          abort_n  = 1'b1;
        end else if (cg_cell_end && cg_cell_idx == LAST_CELL) begin
          state_n = ST_GAP;
          done_n  = 1'b1;
        end
      end
      ST_HOST_HOLD: begin
        if (clk_s) begin
          if (!data_s) begin
            state_n  = ST_RX;
            cg_start = 1'b1;
            cg_mode  = MODE_RX;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_RX: begin
        if (cg_cell_end && cg_cell_idx == STOP_CELL) begin
          if (rx_bits[STOP_CELL]) state_n = ST_ACK;
          else begin
            state_n  = ST_GAP;
            cg_clear = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (cg_cell_end) begin
          state_n = ST_GAP;
          valid_n = 1'b1;
        end
      end
      ST_GAP: begin
        if (!clk_s && clk_hist == 3'b000) state_n = ST_HOST_HOLD;
        else if (bus_idle) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign ps2_clk_oe  = (state == ST_TX || state == ST_RX || state == ST_ACK) && !cg_phase_high;
  assign ps2_data_oe = (state == ST_TX) ? ~tx_frame[cg_cell_idx] : (state == ST_ACK);

endmodule

// File: tb/tb_ps2_device_rxtx.sv
// Self-checking bench for ps2_device_rxtx acting as a PS/2 host with open-drain line model.
module tb_ps2_device_rxtx;

  localparam int HALF = 4;
  localparam int GAP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       tx_stb = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_abort, rx_valid, rx_parity_err;
  logic [7:0] rx_data;
  wire        ps2_clk_line  = !(ps2_clk_oe || host_clk_low);
  wire        ps2_data_line = !(ps2_data_oe || host_data_low);

  int compared = 0;
  int mismatched = 0;
  int falls = 0, done_cnt = 0, abort_cnt = 0, valid_cnt = 0, ready_cycles = 0;
  logic prev_clk_line = 1'b1;
  logic fall_bits[$];

  ps2_device_rxtx #(.HALF_CYCLES(HALF), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk_in    (ps2_clk_line),
    .ps2_data_in   (ps2_data_line),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .tx_stb        (tx_stb),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .tx_done       (tx_done),
    .tx_abort      (tx_abort),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  // Host-side observer: records data at every PS/2 clock falling edge and counts pulses
  always @(negedge clk) begin
    if (prev_clk_line && !ps2_clk_line) begin
      falls++;
      fall_bits.push_back(ps2_data_line);
    end
    prev_clk_line = ps2_clk_line;
    if (tx_done)  done_cnt++;
    if (tx_abort) abort_cnt++;
    if (rx_valid) valid_cnt++;
    if (tx_ready) ready_cycles++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int popcount8(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return n;
  endfunction

  function automatic logic [10:0] model_tx_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (popcount8(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic model_perr(input logic [7:0] b, input logic p);
    return ((popcount8(b) + int'(p)) % 2) == 0;
  endfunction

  function automatic int count_of(input int which);
    case (which)
      0: return falls;
      1: return done_cnt;
      2: return abort_cnt;
      3: return valid_cnt;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_event(input string tag, input int which, input int bound);
    int c0 = count_of(which);
    int n = 0;
    while (count_of(which) == c0 && n < bound) begin
      tick();
      n++;
    end
    check_output(tag, count_of(which) - c0, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 60) begin
      tick();
      n++;
    end
    check_output(tag, tx_ready, 1);
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] b);
    tx_data = b;
    tx_stb  = 1'b1;
    tick();
    tx_stb  = 1'b0;
    check_output({tag, "_ready_drop"}, tx_ready, 0);
  endtask

  task automatic check_tx_frame(input string tag, input logic [7:0] b);
    logic [10:0] obs = '0;
    check_output({tag, "_len"}, fall_bits.size(), 11);
    for (int i = 0; i < 11; i++) if (i < fall_bits.size()) obs[i] = fall_bits[i];
    check_output({tag, "_bits"}, {21'd0, obs}, {21'd0, model_tx_frame(b)});
  endtask

  task automatic host_request();
    host_clk_low = 1'b1;
    repeat (100) tick();
    host_data_low = 1'b1;
    repeat (5) tick();
    host_clk_low = 1'b0;
  endtask

  task automatic host_shift(input string tag, input logic [7:0] b, input logic p, input logic stop);
    logic [9:0] bits = {stop, p, b};
    for (int i = 0; i < 10; i++) begin
      wait_event({tag, "_fall"}, 0, 200);
      host_data_low = !bits[i];
    end
    if (stop) begin
      wait_event({tag, "_ack_fall"}, 0, 200);
      check_output({tag, "_ack"}, ps2_data_oe, 1);
      host_data_low = 1'b0;
    end
  endtask

  task automatic host_frame(input string tag, input logic [7:0] b, input logic p);
    wait_ready({tag, "_pre"});
    host_request();
    host_shift(tag, b, p, 1'b1);
    wait_event({tag, "_valid"}, 3, 200);
    check_output({tag, "_data"}, rx_data, b);
    check_output({tag, "_perr"}, rx_parity_err, model_perr(b, p));
  endtask

  initial begin
    logic [7:0] b;
    logic p;
    int a0, r0, v0, f0;
    logic [10:0] q;

    repeat (3) tick();
    check_output("reset_outputs",
                 {16'd0, ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_abort, rx_valid,
                  rx_parity_err, 1'b0, rx_data}, 32'd0);
    rst = 1'b1;

    wait_ready("ready_after_reset");
    fall_bits.delete();
    apply_stimulus("tx1c", 8'h1C);
    wait_event("tx1c_done", 1, 400);
    check_tx_frame("tx1c", 8'h1C);
    q = '0;
    for (int i = 0; i < 11; i++) if (i < fall_bits.size()) q[i] = fall_bits[i];
    check_output("tx1c_literal", {21'd0, q}, 32'h438);
    wait_ready("tx1c_ready_again");

    host_frame("rx_ed_ok", 8'hED, 1'b1);
    host_frame("rx_ed_bad", 8'hED, 1'b0);

    wait_ready("ab_pre");
    a0 = abort_cnt;
    fall_bits.delete();
    apply_stimulus("ab", 8'hAA);
    repeat (4) wait_event("ab_fall", 0, 200);
    for (int n = 0; n < 20 && !ps2_clk_line; n++) tick();
    host_clk_low = 1'b1;
    wait_event("ab_abort", 2, 40);
    check_output("ab_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (50) tick();
    host_clk_low = 1'b0;
    tick();
    fall_bits.delete();
    wait_event("ab_retry_done", 1, 400);
    check_tx_frame("ab_resend", 8'hAA);
    check_output("ab_abort_once", abort_cnt - a0, 1);

    wait_ready("rts_pre");
    host_clk_low  = 1'b1;
    host_data_low = 1'b1;
    tick();
    tick();
    check_output("rts_ready_at_stb", tx_ready, 1);
    r0 = ready_cycles;
    tx_data = 8'h55;
    tx_stb  = 1'b1;
    tick();
    tx_stb  = 1'b0;
    repeat (98) tick();
    host_clk_low = 1'b0;
    host_shift("rts", 8'hFF, 1'b1, 1'b1);
    wait_event("rts_valid", 3, 200);
    check_output("rts_data", rx_data, 8'hFF);
    check_output("rts_perr", rx_parity_err, 0);
    fall_bits.delete();
    wait_event("rts_tx_done", 1, 400);
    check_tx_frame("rts_tx55", 8'h55);
    check_output("rts_ready_stayed_low", ready_cycles - r0, 0);

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      wait_ready("rnd_tx_pre");
      fall_bits.delete();
      apply_stimulus("rnd_tx", b);
      wait_event("rnd_tx_done", 1, 400);
      check_tx_frame("rnd_tx", b);
    end

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      host_frame("rnd_rx", b, p);
    end

    wait_ready("bs_pre");
    v0 = valid_cnt;
    b = 8'($urandom);
    host_request();
    host_shift("bs", b, ~^b, 1'b0);
    f0 = falls;
    repeat (40) tick();
    check_output("bs_no_ack_cell", falls - f0, 0);
    check_output("bs_no_valid", valid_cnt - v0, 0);
    check_output("bs_data_released", ps2_data_oe, 0);
    host_data_low = 1'b0;

    wait_ready("rst_pre");
    v0 = valid_cnt;
    b = 8'($urandom);
    host_request();
    for (int i = 0; i < 6; i++) begin
      wait_event("rst_fall", 0, 200);
      host_data_low = !b[i];
    end
    check_output("rst_clk_low_before", ps2_clk_oe, 1);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (3) tick();
    host_data_low = 1'b0;
    rst = 1'b1;
    tick();
    check_output("rst_no_valid", valid_cnt - v0, 0);
    wait_ready("rst_ready_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
